// File: rtl/link_tx_scheduler_pkg.sv
// Shared constants and types for the link transmit scheduler:
// control characters, width-select codes, FSM encoding and requester indices.
package link_tx_pkg;

    localparam logic [7:0] IDLE_CHAR = 8'hBC;  // K28.5
    localparam logic [7:0] SOF_CHAR  = 8'hFB;  // K27.7
    localparam logic [7:0] EOF_CHAR  = 8'hFD;  // K29.7

    localparam int unsigned SYNC_LEN = 4;

    localparam logic [1:0] DS_8  = 2'b00;
    localparam logic [1:0] DS_16 = 2'b01;
    localparam logic [1:0] DS_32 = 2'b10;

    // Bit positions of each requester inside the request/grant vectors.
    localparam int REQ_8  = 0;
    localparam int REQ_16 = 1;
    localparam int REQ_32 = 2;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_IDLE = 3'd1,
        ST_SOF  = 3'd2,
        ST_DATA = 3'd3,
        ST_EOF  = 3'd4
    } state_t;

endpackage

// File: rtl/link_tx_scheduler_rr_arbiter3.sv
// Three-way round-robin arbiter. Priority starts just after the last served
// requester (order 8 -> 16 -> 32 -> 8); the pointer moves only on update_i.
module rr_arbiter3
    import link_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req_i,
    input  logic       update_i,
    output logic [2:0] winner_o
);

    logic [2:0] last_q;
    logic [2:0] last_d;

    always_comb begin
        winner_o = 3'b000;
        case (last_q)
            3'b001: begin
                if      (req_i[REQ_16]) winner_o = 3'b010;
                else if (req_i[REQ_32]) winner_o = 3'b100;
                else if (req_i[REQ_8])  winner_o = 3'b001;
            end
            3'b010: begin
                if      (req_i[REQ_32]) winner_o = 3'b100;
                else if (req_i[REQ_8])  winner_o = 3'b001;
                else if (req_i[REQ_16]) winner_o = 3'b010;
            end
            default: begin
                if      (req_i[REQ_8])  winner_o = 3'b001;
                else if (req_i[REQ_16]) winner_o = 3'b010;
                else if (req_i[REQ_32]) winner_o = 3'b100;
            end
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (update_i && (req_i != 3'b000)) begin
            last_d = winner_o;
        end
    end

    // Reset pointer reads "last served 32" so req8 wins the first contest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 3'b100;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/link_tx_scheduler.sv
// Transmit link scheduler: arbitrates three word sources and serializes the
// granted word MSB-first between SOF/EOF characters, idling with commas.
module link_tx_scheduler
    import link_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enb,
    input  logic        req8,
    input  logic        req16,
    input  logic        req32,
    input  logic [7:0]  dataIn,
    input  logic [15:0] dataIn16,
    input  logic [31:0] dataIn32,
    output logic        gnt8,
    output logic        gnt16,
    output logic        gnt32,
    output logic [1:0]  dataS,
    output logic [7:0]  txByte,
    output logic        txK,
    output logic        busy,
    output state_t      dbg_state_o
);

    // Handshake: a requester holds reqN high until it sees gntN (one cycle,
    // word sampled on that same edge); a req still high at the next
    // arbitration edge is treated as a fresh request.

    state_t      state_q, state_d;
    logic [3:0]  sync_cnt_q, sync_cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [1:0]  ds_q, ds_d;
    logic [7:0]  txbyte_q, txbyte_d;
    logic        txk_q, txk_d;
    logic        busy_q, busy_d;
    logic [2:0]  gnt_q, gnt_d;

    logic [2:0]  req_vec;
    logic [2:0]  winner;
    logic        arb_window;
    logic        grant;

    assign req_vec    = {req32, req16, req8};
    assign arb_window = (state_q == ST_IDLE) || (state_q == ST_EOF);
    assign grant      = enb && arb_window && (req_vec != 3'b000);

    rr_arbiter3 u_arb (
        .clk      (clk),
        .rst_n    (rst),
        .req_i    (req_vec),
        .update_i (grant),
        .winner_o (winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (enb) begin
            case (state_q)
                ST_SYNC: if (sync_cnt_q == 4'(SYNC_LEN - 1)) state_d = ST_IDLE;
                ST_IDLE: if (grant) state_d = ST_SOF;
                ST_SOF:  state_d = ST_DATA;
                ST_DATA: if (byte_cnt_q == 2'd0) state_d = ST_EOF;
                ST_EOF:  state_d = grant ? ST_SOF : ST_IDLE;
                default: state_d = ST_SYNC;
            endcase
        end
    end

    // Output/datapath: every output is the registered image of the symbol
    // that belongs to state_d, so txByte lines up with the FSM state.
    always_comb begin
        sync_cnt_d = sync_cnt_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        ds_d       = ds_q;
        txbyte_d   = txbyte_q;
        txk_d      = txk_q;
        busy_d     = busy_q;
        gnt_d      = 3'b000;
        if (enb) begin
            case (state_q)
                ST_SYNC: begin
                    sync_cnt_d = sync_cnt_q + 4'd1;
                    txbyte_d   = IDLE_CHAR;
                    txk_d      = 1'b1;
                end
                ST_SOF: begin
                    txbyte_d = shift_q[31:24];
                    txk_d    = 1'b0;
                    shift_d  = {shift_q[23:0], 8'h00};
                end
                ST_DATA: begin
                    if (byte_cnt_q == 2'd0) begin
                        txbyte_d = EOF_CHAR;
                        txk_d    = 1'b1;
                    end else begin
                        txbyte_d   = shift_q[31:24];
                        txk_d      = 1'b0;
                        shift_d    = {shift_q[23:0], 8'h00};
                        byte_cnt_d = byte_cnt_q - 2'd1;
                    end
                end
                default: begin
                    txbyte_d = grant ? SOF_CHAR : IDLE_CHAR;
                    txk_d    = 1'b1;
                end
            endcase

            if (grant) begin
                gnt_d = winner;
                case (winner)
                    3'b001: begin
                        shift_d    = {dataIn, 24'h000000};
                        byte_cnt_d = 2'd0;
                        ds_d       = DS_8;
                    end
                    3'b010: begin
                        shift_d    = {dataIn16, 16'h0000};
                        byte_cnt_d = 2'd1;
                        ds_d       = DS_16;
                    end
                    default: begin
                        shift_d    = dataIn32;
                        byte_cnt_d = 2'd3;
                        ds_d       = DS_32;
                    end
                endcase
            end

            busy_d = (state_d == ST_SOF) || (state_d == ST_DATA) || (state_d == ST_EOF);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_cnt_q <= 4'd0;
            shift_q    <= 32'h0;
            byte_cnt_q <= 2'd0;
            ds_q       <= DS_8;
            txbyte_q   <= IDLE_CHAR;
            txk_q      <= 1'b1;
            busy_q     <= 1'b0;
            gnt_q      <= 3'b000;
        end else begin
            sync_cnt_q <= sync_cnt_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            ds_q       <= ds_d;
            txbyte_q   <= txbyte_d;
            txk_q      <= txk_d;
            busy_q     <= busy_d;
            gnt_q      <= gnt_d;
        end
    end

    assign gnt8        = gnt_q[REQ_8];
    assign gnt16       = gnt_q[REQ_16];
    assign gnt32       = gnt_q[REQ_32];
    assign dataS       = ds_q;
    assign txByte      = txbyte_q;
    assign txK         = txk_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule
